barker_corr_stream: RTL
=======================

Name: barker_corr_stream

Overview:
Parametrised, soft-input successor to the 1-bit Barker correlator. It accepts signed multi-bit samples on an AXI-stream slave, correlates a sliding window against a compile-time-selected Barker code, and emits the correlation value on an AXI-stream master with full backpressure. It also performs runtime-threshold peak detection with polarity, handles frame boundaries on tlast, and keeps a saturating peak counter. It sits between the sample front-end and the frame-sync logic.

Parameters:
CODE_LEN, 13, Barker length; legal values 2, 3, 4, 5, 7, 11, 13; any other value is an elaboration error.
DATA_W, 8, signed input sample width.
ACC_W, DATA_W+$clog2(CODE_LEN), signed correlation width (derived; do not override).
CNT_W, 16, peak counter width.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
s_tdata  in  DATA_W  signed sample
s_tvalid  in  1  sample valid
s_tready  out  1  sample accept
s_tlast  in  1  last sample of frame
m_tdata  out  ACC_W  signed correlation
m_tvalid  out  1  result valid
m_tready  in  1  downstream ready
m_tlast  out  1  frame end, aligned with the input tlast sample
m_tuser  out  3  [0] peak, [1] polarity (1 = negative), [2] window_full
i_threshold  in  ACC_W  unsigned peak threshold
i_cnt_clr  in  1  synchronous peak-counter clear
o_peak_count  out  CNT_W  saturating peak count

Behaviour:
- Reset: one clock; i_rst is asynchronous and active-high. While i_rst is high, m_tvalid, m_tdata, m_tlast, m_tuser, o_peak_count, the window register and the fill counter are all 0, and s_tready=0.
- Handshake: s_tready = !i_rst && (!m_tvalid || m_tready). A sample is accepted when s_tvalid && s_tready.
- Output register: m_tvalid rises the cycle after acceptance, so latency is 1 cycle.
- Backpressure: while m_tvalid && !m_tready, m_tdata, m_tuser and m_tlast hold stable. Accept and emit can occur in the same cycle, giving 1 sample/cycle throughput. m_tvalid falls only on an m-handshake with no new acceptance.
- Window: on acceptance, the CODE_LEN-deep shift register shifts and the new sample becomes x[n]. Unfilled positions hold 0.
- Correlation: corr = sum over k=0..CODE_LEN-1 of c[k]*x[n-CODE_LEN+1+k], where c[0] multiplies the oldest sample. Computation is exact in ACC_W signed; no overflow is possible (|corr| <= CODE_LEN*2^(DATA_W-1)). It is computed over the updated window, including the current sample.
- Codes, with c[0] first:
  - 13: ++++ +--+ +-+-+
  - 11: +++- --+- -+-
  - 7: +++- -+-
  - 5: +++-+
  - 4: ++-+
  - 3: ++-
  - 2: +-
- Fill counter: saturates at CODE_LEN and counts accepted samples of the current frame. window_full = (fill count after this acceptance == CODE_LEN).
- Peak detection: peak = window_full && |corr| >= i_threshold, with i_threshold sampled at acceptance. polarity = peak && corr<0; it is 0 when peak=0. i_threshold=0 flags a peak on every window_full beat.
- Frame boundary: on an accepted s_tlast, the output beat carries m_tlast=1 and is computed normally. In the same cycle the window clears to 0 and the fill counter resets to 0, so the next sample starts a fresh frame. No cross-frame correlation occurs.
- Peak counter: increments by 1 on each m-handshake (m_tvalid && m_tready) with m_tuser[0]=1, and saturates at all-ones. If i_cnt_clr coincides with an increment, clear wins and the counter becomes 0.
- Reset mid-operation: the pending output is discarded immediately. The first sample after reset is treated as sample 1 of a new frame.

Test Plan:
- Defaults, i_threshold=100, m_tready=1. Feed the 13-code with amplitude +10 (c[k]*10) → the 13th output gives m_tdata=130 and m_tuser=3'b101. Outputs 1–12 have window_full=0 and peak=0. o_peak_count=1.
- Same stimulus with amplitude -10 → 13th output gives m_tdata=-130 and m_tuser=3'b111.
- Backpressure: hold m_tready=0 for 5 cycles mid-stream → s_tready=0 after the first beat and m_tdata stays stable. Resuming yields an identical result sequence with no loss or duplication. Randomised ready/valid over 1000 samples matches the reference model.
- Frame: assert s_tlast on sample 13 of a matched code, then send 13 more matched samples → both frames peak at output 13 of their frame with m_tlast=1 on output 13 of frame 1. Frame 2 outputs 1–12 show window_full=0.
- Counter: generate 3 peaks, pulse i_cnt_clr coincident with the 3rd peak handshake → o_peak_count=0. With CNT_W=2, generate 5 peaks → o_peak_count=3.
- Assert i_rst mid-frame with m_tvalid=1 → all outputs 0 asynchronously. After release, a full 7-code run with CODE_LEN=7, DATA_W=4, amplitude +7 → m_tdata=49 on the 7th sample.

Source files
------------

// File: rtl/barker_corr_stream.sv
// barker_corr_stream: soft-input sliding-window Barker correlator.
// Signed samples arrive on an AXI-stream slave. Each accepted sample yields one
// correlation beat on an AXI-stream master. The beat carries peak and polarity
// flags. Frames are delimited by tlast, and a saturating counter tracks peaks.
//
// Handshake (both ports): a transfer happens on a rising clock edge where
// tvalid && tready. A master holds tdata/tuser/tlast stable while tvalid is high
// and tready is low. s_tready is (!m_tvalid || m_tready), so a new sample is
// taken only when the output register is empty or is being drained in the same
// cycle.
module barker_corr_stream #(
  parameter int CODE_LEN = 13,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = DATA_W + $clog2(CODE_LEN),
  parameter int CNT_W    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [ACC_W-1:0]        m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [2:0]              m_tuser,
  input  logic [ACC_W-1:0]        i_threshold,
  input  logic                    i_cnt_clr,
  output logic [CNT_W-1:0]        o_peak_count
);

  localparam int FILL_W = $clog2(CODE_LEN + 1);

  // Bit k is 1 when code chip c[k] is '+'. c[0] weights the oldest sample.
  function automatic logic [12:0] code_mask(input int len);
    logic [12:0] m;
    case (len)
      13:      m = 13'b1010110011111;
      11:      m = 13'b0001001000111;
      7:       m = 13'b0000000100111;
      5:       m = 13'b0000000010111;
      4:       m = 13'b0000000001011;
      3:       m = 13'b0000000000011;
      2:       m = 13'b0000000000001;
      default: m = 13'b0000000000000;
    endcase
    return m;
  endfunction

  localparam logic [12:0] CODE_MASK = code_mask(CODE_LEN);

  // Only the known Barker lengths exist.
  if (!(CODE_LEN == 2 || CODE_LEN == 3 || CODE_LEN == 4 || CODE_LEN == 5 ||
        CODE_LEN == 7 || CODE_LEN == 11 || CODE_LEN == 13)) begin : g_bad_code_len
    $error("barker_corr_stream: CODE_LEN must be one of 2,3,4,5,7,11,13");
  end

  logic signed [DATA_W-1:0] r_win [CODE_LEN];
  logic signed [DATA_W-1:0] w_win [CODE_LEN];
  logic [FILL_W-1:0]        r_fill;
  logic [FILL_W-1:0]        w_fill_nx;
  logic                     w_full;
  logic signed [ACC_W-1:0]  w_corr;
  logic [ACC_W-1:0]         w_abs;
  logic                     w_peak;
  logic                     w_pol;
  logic                     w_accept;
  logic                     w_cnt_inc;

  logic                     r_m_tvalid;
  logic [ACC_W-1:0]         r_m_tdata;
  logic                     r_m_tlast;
  logic [2:0]               r_m_tuser;
  logic [CNT_W-1:0]         r_peak_count;

  assign s_tready  = !i_rst && (!r_m_tvalid || m_tready);
  assign w_accept  = s_tvalid && s_tready;

  // Window as it looks after the current sample shifts in (index CODE_LEN-1 newest).
  always_comb begin
    for (int k = 0; k < CODE_LEN - 1; k++) begin
      w_win[k] = r_win[k+1];
    end
    w_win[CODE_LEN-1] = $signed(s_tdata);
  end

  // Exact correlation of the updated window against the code.
  always_comb begin
    w_corr = '0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (CODE_MASK[k]) begin
        w_corr = w_corr + ACC_W'(w_win[k]);
      end else begin
        w_corr = w_corr - ACC_W'(w_win[k]);
      end
    end
  end

  // Fill level, magnitude and peak decision for the beat being produced.
  always_comb begin
    w_fill_nx = (r_fill == FILL_W'(CODE_LEN)) ? r_fill : r_fill + 1'b1;
    w_full    = (w_fill_nx == FILL_W'(CODE_LEN));
    w_abs     = w_corr[ACC_W-1] ? ACC_W'(-w_corr) : ACC_W'(w_corr);
    w_peak    = w_full && (w_abs >= i_threshold);
    w_pol     = w_peak && w_corr[ACC_W-1];
  end

  // Sample window and fill counter; a frame end wipes both.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < CODE_LEN; k++) r_win[k] <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      if (s_tlast) begin
        for (int k = 0; k < CODE_LEN; k++) r_win[k] <= '0;
        r_fill <= '0;
      end else begin
        for (int k = 0; k < CODE_LEN; k++) r_win[k] <= w_win[k];
        r_fill <= w_fill_nx;
      end
    end
  end

  // Output register: load on accept, drop valid once drained with nothing new.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_corr;
      r_m_tlast  <= s_tlast;
      r_m_tuser  <= {w_full, w_pol, w_peak};
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign w_cnt_inc = r_m_tvalid && m_tready && r_m_tuser[0];

  // Saturating peak counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_peak_count <= '0;
    end else if (i_cnt_clr) begin
      r_peak_count <= '0;
    end else if (w_cnt_inc && !(&r_peak_count)) begin
      r_peak_count <= r_peak_count + 1'b1;
    end
  end

  assign m_tvalid     = r_m_tvalid;
  assign m_tdata      = r_m_tdata;
  assign m_tlast      = r_m_tlast;
  assign m_tuser      = r_m_tuser;
  assign o_peak_count = r_peak_count;

endmodule
